counter_bcd_updown_n_digits: RTL and testbench

- Generalised N-digit BCD counter for the board display path: DIGITS decades, up/down direction, synchronous parallel load, wrap or saturate at limits, built-in tick prescaler.
- Entire block runs in the CLOCK_50 domain; digits advance via single-cycle enables, never via derived or rippled clocks.
- Drives per-digit 7-segment outputs (active-low) plus limit and wrap flags for downstream timer/alarm logic.

---
 rtl/counter_bcd_updown_n_digits_pkg.sv | 35 +++
 rtl/counter_bcd_updown_n_digits_digit.sv | 36 +++
 rtl/counter_bcd_updown_n_digits.sv | 90 +++++++++
 tb/tb_counter_bcd_updown_n_digits.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_bcd_updown_n_digits_pkg.sv
// Shared constants and helpers for the N-digit BCD up/down counter.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: BCD_MAX, SEG_DIGIT active-low segment table, seg7_decode(), bcd_clamp().
package counter_bcd_updown_n_digits_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Active-low segments {g,f,e,d,c,b,a}; entry 9 is the leftmost element.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  // Codes above 9 cannot reach the decoder once loads are clamped; blank them anyway.
  function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
    logic [6:0] seg;
    seg = 7'h7F;
    if (digit <= BCD_MAX) seg = SEG_DIGIT[digit];
    return seg;
  endfunction

  function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/counter_bcd_updown_n_digits_digit.sv
// One BCD decade of the up/down counter: loads a clamped digit or steps by one with wrap 9<->0.
// Latency: digit updates on the clock edge after load/step_in; is_nine/is_zero are combinational.
// Backpressure: none; step_in is a single-cycle enable from the carry/borrow chain.
// Ports: clk, rst_n (sync active-low), step_in, up, load, load_digit -> digit, is_nine, is_zero.
module bcd_digit_updown
  import counter_bcd_updown_n_digits_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_in,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_digit,
  output logic [3:0] digit,
  output logic       is_nine,
  output logic       is_zero
);

  logic [3:0] r_digit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_digit <= 4'd0;
    end else if (load) begin
      r_digit <= bcd_clamp(load_digit);
    end else if (step_in) begin
      if (up) r_digit <= (r_digit == BCD_MAX) ? 4'd0 : r_digit + 4'd1;
      else    r_digit <= (r_digit == 4'd0) ? BCD_MAX : r_digit - 4'd1;
    end
  end

  assign digit   = r_digit;
  assign is_nine = (r_digit == BCD_MAX);
  assign is_zero = (r_digit == 4'd0);

endmodule

// File: rtl/counter_bcd_updown_n_digits.sv
// N-digit BCD up/down counter with prescaler, parallel load, wrap/saturate and 7-seg outputs.
// Latency: count steps on the edge where the prescaler returns to 0; load visible next cycle.
// Backpressure: none; enable low freezes prescaler and count.
// Ports: CLOCK_50, aclr (sync active-low), enable, up, saturate, load, load_val
//        -> bcd, HEX (active-low), max, min, wrap (one-cycle pulse).
module counter_bcd_updown_n_digits
  import counter_bcd_updown_n_digits_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int TICK_DIV = 50000000,
  parameter int PRESC_W  = 26
) (
  input  logic                  CLOCK_50,
  input  logic                  aclr,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  saturate,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   HEX,
  output logic                  max,
  output logic                  min,
  output logic                  wrap
);

  localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] r_presc;
  logic               r_wrap;

  logic               w_tick;
  logic               w_at_limit;
  logic               w_step;
  logic [DIGITS-1:0]  w_is_nine;
  logic [DIGITS-1:0]  w_is_zero;
  logic [DIGITS-1:0]  w_step_in;
  // Entry i: every digit below i is nine (or zero); entry DIGITS covers the whole count.
  logic [DIGITS:0]    w_nine_below;
  logic [DIGITS:0]    w_zero_below;

  assign w_tick     = enable && (r_presc == TICK_LAST);
  assign w_at_limit = up ? w_nine_below[DIGITS] : w_zero_below[DIGITS];
  // Saturation simply suppresses the step at the limit, so no digit moves.
  assign w_step     = w_tick && !(w_at_limit && saturate);

  always_ff @(posedge CLOCK_50) begin
    if (!aclr) begin
      r_presc <= '0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_presc <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= w_step && w_at_limit;
      if (enable) r_presc <= (r_presc == TICK_LAST) ? '0 : r_presc + PRESC_W'(1);
    end
  end

  assign w_nine_below[0] = 1'b1;
  assign w_zero_below[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] w_digit;

    assign w_nine_below[i+1] = w_nine_below[i] && w_is_nine[i];
    assign w_zero_below[i+1] = w_zero_below[i] && w_is_zero[i];
    assign w_step_in[i]      = w_step && (up ? w_nine_below[i] : w_zero_below[i]);

    bcd_digit_updown u_digit (
      .clk        (CLOCK_50),
      .rst_n      (aclr),
      .step_in    (w_step_in[i]),
      .up         (up),
      .load       (load),
      .load_digit (load_val[4*i +: 4]),
      .digit      (w_digit),
      .is_nine    (w_is_nine[i]),
      .is_zero    (w_is_zero[i])
    );

    assign bcd[4*i +: 4] = w_digit;
    assign HEX[7*i +: 7] = seg7_decode(w_digit);
  end

  assign max  = w_nine_below[DIGITS];
  assign min  = w_zero_below[DIGITS];
  assign wrap = r_wrap;

endmodule

// File: tb/tb_counter_bcd_updown_n_digits.sv
// Bench for counter_bcd_updown_n_digits: two instances (TICK_DIV=4 and TICK_DIV=1) on shared stimulus.
// Expected state comes from a decimal-integer reference model pushed to a queue each cycle.
module tb_counter_bcd_updown_n_digits;

  localparam int D = 3;
  localparam int W = 4 * D;
  localparam int LIM = 999;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         aclr, enable, up, saturate, load;
  logic [W-1:0] load_val;

  logic [W-1:0]   bcd_a, bcd_b;
  logic [7*D-1:0] hex_a, hex_b;
  logic           max_a, max_b, min_a, min_b, wrap_a, wrap_b;

  counter_bcd_updown_n_digits #(.DIGITS(D), .TICK_DIV(4), .PRESC_W(3)) dut_a (
    .CLOCK_50(clk), .aclr(aclr), .enable(enable), .up(up), .saturate(saturate),
    .load(load), .load_val(load_val), .bcd(bcd_a), .HEX(hex_a),
    .max(max_a), .min(min_a), .wrap(wrap_a)
  );

  counter_bcd_updown_n_digits #(.DIGITS(D), .TICK_DIV(1), .PRESC_W(1)) dut_b (
    .CLOCK_50(clk), .aclr(aclr), .enable(enable), .up(up), .saturate(saturate),
    .load(load), .load_val(load_val), .bcd(bcd_b), .HEX(hex_b),
    .max(max_b), .min(min_b), .wrap(wrap_b)
  );

  typedef struct {
    int val_a;
    int wrap_a;
    int val_b;
    int wrap_b;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_val[2];
  int   m_presc[2];
  int   m_wrap[2];
  int   tdiv[2] = '{4, 1};

  function automatic int bcd2int(input logic [W-1:0] b);
    int v = 0;
    for (int i = D - 1; i >= 0; i--) begin
      int d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [7*D-1:0] hex_of(input int v);
    logic [7*D-1:0] h = '0;
    int t = v;
    for (int i = 0; i < D; i++) begin
      h[7*i +: 7] = seg(t % 10);
      t = t / 10;
    end
    return h;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int k);
    if (!aclr) begin
      m_val[k] = 0; m_presc[k] = 0; m_wrap[k] = 0;
    end else if (load) begin
      m_val[k] = bcd2int(load_val); m_presc[k] = 0; m_wrap[k] = 0;
    end else begin
      m_wrap[k] = 0;
      if (enable) begin
        if (m_presc[k] == tdiv[k] - 1) begin
          m_presc[k] = 0;
          if (up) begin
            if (m_val[k] != LIM) m_val[k] = m_val[k] + 1;
            else if (!saturate) begin m_val[k] = 0; m_wrap[k] = 1; end
          end else begin
            if (m_val[k] != 0) m_val[k] = m_val[k] - 1;
            else if (!saturate) begin m_val[k] = LIM; m_wrap[k] = 1; end
          end
        end else begin
          m_presc[k] = m_presc[k] + 1;
        end
      end
    end
  endtask

  task automatic check_dut(input string n, input logic [W-1:0] b, input logic [7*D-1:0] h,
                           input logic mx, input logic mn, input logic wr,
                           input int ev, input int ew);
    chk({n, "_bcd"},  32'(b),  32'(int2bcd(ev)));
    chk({n, "_hex"},  32'(h),  32'(hex_of(ev)));
    chk({n, "_max"},  32'(mx), 32'(ev == LIM));
    chk({n, "_min"},  32'(mn), 32'(ev == 0));
    chk({n, "_wrap"}, 32'(wr), 32'(ew));
  endtask

  task automatic cycle();
    exp_t e;
    model_edge(0);
    model_edge(1);
    e.val_a = m_val[0]; e.wrap_a = m_wrap[0];
    e.val_b = m_val[1]; e.wrap_b = m_wrap[1];
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check_dut("a", bcd_a, hex_a, max_a, min_a, wrap_a, e.val_a, e.wrap_a);
    check_dut("b", bcd_b, hex_b, max_b, min_b, wrap_b, e.val_b, e.wrap_b);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    aclr = 1'b0; enable = 1'b1; up = 1'b1; saturate = 1'b0; load = 1'b0; load_val = '0;
    m_val = '{0, 0}; m_presc = '{0, 0}; m_wrap = '{0, 0};

    // Reset held with enable high.
    cycles(3);
    chk("rst_bcd", 32'(bcd_a), 32'h000);
    chk("rst_hex", 32'(hex_a), 32'h102040);
    chk("rst_min", 32'(min_a), 32'd1);

    // Count up: one step per 4 cycles on dut_a.
    aclr = 1'b1;
    cycles(40);
    chk("up40_bcd", 32'(bcd_a), 32'h010);
    enable = 1'b0;
    cycles(10);
    chk("freeze_bcd", 32'(bcd_a), 32'h010);
    enable = 1'b1;

    // Wrap with saturate off (dut_b steps every cycle).
    load_val = 12'h998; load = 1'b1; cycle(); load = 1'b0;
    cycle();
    chk("wrap_999", 32'(bcd_b), 32'h999);
    cycle();
    chk("wrap_000", 32'(bcd_b), 32'h000);
    chk("wrap_pulse", 32'(wrap_b), 32'd1);
    cycle();
    chk("wrap_drop", 32'(wrap_b), 32'd0);

    // Saturate at all nines.
    saturate = 1'b1;
    load = 1'b1; cycle(); load = 1'b0;
    cycles(4);
    chk("sat_hold", 32'(bcd_b), 32'h999);
    chk("sat_max", 32'(max_b), 32'd1);

    // Down borrow and underflow wrap.
    saturate = 1'b0; up = 1'b0;
    load_val = 12'h100; load = 1'b1; cycle(); load = 1'b0;
    cycle();
    chk("dn_099", 32'(bcd_b), 32'h099);
    cycle();
    chk("dn_098", 32'(bcd_b), 32'h098);
    load_val = 12'h000; load = 1'b1; cycle(); load = 1'b0;
    cycle();
    chk("dn_wrap_999", 32'(bcd_b), 32'h999);
    chk("dn_wrap_pulse", 32'(wrap_b), 32'd1);

    // Load on dut_a's step cycle: clamp wins, prescaler restarts.
    up = 1'b1;
    for (int n = 0; n < 8 && m_presc[0] != 3; n++) cycle();
    load_val = 12'h3AF; load = 1'b1; cycle(); load = 1'b0;
    chk("ld_clamp", 32'(bcd_a), 32'h399);
    cycles(3);
    chk("ld_nostep", 32'(bcd_a), 32'h399);
    cycle();
    chk("ld_step", 32'(bcd_a), 32'h400);

    // Reset while dut_b's wrap is pulsing.
    load_val = 12'h999; load = 1'b1; cycle(); load = 1'b0;
    cycle();
    chk("mid_wrap_pulse", 32'(wrap_b), 32'd1);
    aclr = 1'b0;
    cycle();
    chk("mid_rst_wrap", 32'(wrap_b), 32'd0);
    chk("mid_rst_bcd", 32'(bcd_b), 32'h000);
    aclr = 1'b1;
    cycles(3);
    chk("rel_nostep", 32'(bcd_a), 32'h000);
    cycle();
    chk("rel_step", 32'(bcd_a), 32'h001);
    cycles(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
